// File: rtl/coo_dense_compressor_pkg.sv
// Shared types and helpers for the dense-to-COO compressor: FSM states,
// the pad row value, and a width-parameterised COO entry packing.
package coo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    EMIT = 1'b1
  } coo_state_e;

  localparam int MAX_ADDR_WIDTH = 64;

  // All-ones in the low addr_width bits; callers size-cast to their width.
  function automatic logic [MAX_ADDR_WIDTH-1:0] pad_row(input int addr_width);
    pad_row = '0;
    for (int i = 0; i < MAX_ADDR_WIDTH; i++) begin
      if (i < addr_width) pad_row[i] = 1'b1;
    end
  endfunction

endpackage

`define COO_ENTRY_T(XW, AW) struct packed { logic [(XW)-1:0] data; logic [(AW)-1:0] row; logic [(AW)-1:0] col; }

// File: rtl/coo_dense_compressor_row_compactor.sv
// Combinational row compaction: picks the first min(NZN_ROW, room) non-zeros
// of a dense row and assigns them consecutive slots starting at base.
module coo_row_compactor #(
  parameter int M       = 2,
  parameter int X_WIDTH = 8,
  parameter int SLOT_W  = 3,
  parameter int NZN_ROW = 2,
  parameter int CNT_W   = 2
) (
  input  logic [M*X_WIDTH-1:0] row_data,
  input  logic [SLOT_W-1:0]    base,
  input  logic [SLOT_W-1:0]    room,
  output logic [M-1:0]         wr_en,
  output logic [M*SLOT_W-1:0]  wr_slot,
  output logic [SLOT_W-1:0]    wr_cnt
`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
  ,
  output logic [CNT_W-1:0]     nz_cnt
`endif
);

  int cnt;
  int limit;

  always_comb begin
    wr_en   = '0;
    wr_slot = '0;
    cnt     = 0;
    limit   = (int'(room) < NZN_ROW) ? int'(room) : NZN_ROW;
`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
    nz_cnt  = '0;
`endif
    for (int m = 0; m < M; m++) begin
      if (row_data[m*X_WIDTH +: X_WIDTH] != '0) begin
`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
        nz_cnt = nz_cnt + CNT_W'(1);
`endif
        if (cnt < limit) begin
          wr_en[m] = 1'b1;
          wr_slot[m*SLOT_W +: SLOT_W] = SLOT_W'(int'(base) + cnt);
          cnt = cnt + 1;
        end
      end
    end
    wr_cnt = SLOT_W'(cnt);
  end

endmodule

// File: rtl/coo_dense_compressor.sv
// Dense row stream to fixed-capacity COO frame packer for coo_simple_matmul.
// Optional macro COO_COMPRESSOR_OVERFLOW_STATUS_EN adds drop status outputs.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready;
// the sender holds data stable while valid is high and ready is low, and
// x_valid never falls without a completed transfer.
module coo_dense_compressor
  import coo_pkg::*;
#(
  parameter int N          = 2,
  parameter int M          = 2,
  parameter int X_WIDTH    = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NZN        = 4,
  parameter int NZN_ROW    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [M*X_WIDTH-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NZN*X_WIDTH-1:0]     x_data,
  output logic [NZN*ADDR_WIDTH-1:0]  x_row_table,
  output logic [NZN*ADDR_WIDTH-1:0]  x_col_table,
  output logic                       x_valid,
  input  logic                       x_ready
`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
  ,
  output logic                       out_overflow,
  output logic [$clog2(N*M+1)-1:0]   dropped_cnt
`endif
);

  localparam int SLOT_W = $clog2(NZN + 1);
  localparam int ROW_W  = $clog2(N + 1);
  localparam int CNT_W  = $clog2(M + 1);
  localparam logic [ADDR_WIDTH-1:0] PAD_ROW = ADDR_WIDTH'(pad_row(ADDR_WIDTH));

  typedef `COO_ENTRY_T(X_WIDTH, ADDR_WIDTH) entry_t;
  localparam entry_t PAD_ENTRY = '{data: '0, row: PAD_ROW, col: '0};

  coo_state_e           state_q, state_d;
  logic [ROW_W-1:0]     row_cnt;
  logic [SLOT_W-1:0]    fill_cnt;
  logic [SLOT_W-1:0]    room;
  entry_t               slot_q [NZN];
  logic                 accept, emit_hs;
  logic [M-1:0]         wr_en;
  logic [M*SLOT_W-1:0]  wr_slot;
  logic [SLOT_W-1:0]    wr_cnt;
`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
  logic [CNT_W-1:0]     nz_cnt;
`endif

  assign room    = SLOT_W'(NZN) - fill_cnt;
  assign accept  = in_valid && in_ready;
  assign emit_hs = x_valid && x_ready;

  coo_row_compactor #(
    .M(M), .X_WIDTH(X_WIDTH), .SLOT_W(SLOT_W), .NZN_ROW(NZN_ROW), .CNT_W(CNT_W)
  ) u_compactor (
    .row_data (in_data),
    .base     (fill_cnt),
    .room     (room),
    .wr_en    (wr_en),
    .wr_slot  (wr_slot),
    .wr_cnt   (wr_cnt)
`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
    ,
    .nz_cnt   (nz_cnt)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    x_valid  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && row_cnt == ROW_W'(N - 1)) state_d = EMIT;
      end
      EMIT: begin
        x_valid = 1'b1;
        if (x_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // A completed frame handshake re-pads the buffer exactly like reset.
  always_ff @(posedge clk) begin
    if (rst || emit_hs) begin
      row_cnt  <= '0;
      fill_cnt <= '0;
      for (int s = 0; s < NZN; s++) slot_q[s] <= PAD_ENTRY;
    end else if (accept) begin
      row_cnt  <= row_cnt + ROW_W'(1);
      fill_cnt <= fill_cnt + wr_cnt;
      for (int s = 0; s < NZN; s++) begin
        for (int m = 0; m < M; m++) begin
          if (wr_en[m] && wr_slot[m*SLOT_W +: SLOT_W] == SLOT_W'(s)) begin
            slot_q[s] <= '{data: in_data[m*X_WIDTH +: X_WIDTH],
                           row:  ADDR_WIDTH'(row_cnt),
                           col:  ADDR_WIDTH'(m)};
          end
        end
      end
    end
  end

  for (genvar s = 0; s < NZN; s++) begin : g_out
    assign x_data[s*X_WIDTH +: X_WIDTH]         = slot_q[s].data;
    assign x_row_table[s*ADDR_WIDTH +: ADDR_WIDTH] = slot_q[s].row;
    assign x_col_table[s*ADDR_WIDTH +: ADDR_WIDTH] = slot_q[s].col;
  end

`ifdef COO_COMPRESSOR_OVERFLOW_STATUS_EN
  localparam int DROP_W = $clog2(N*M + 1);
  logic [DROP_W-1:0] drop_q;
  logic              ovf_q;

  always_ff @(posedge clk) begin
    if (rst || emit_hs) begin
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      drop_q <= drop_q + DROP_W'(nz_cnt) - DROP_W'(wr_cnt);
      if (DROP_W'(nz_cnt) != DROP_W'(wr_cnt)) ovf_q <= 1'b1;
    end
  end

  assign out_overflow = ovf_q;
  assign dropped_cnt  = drop_q;
`endif

endmodule

// File: doc/coo_dense_compressor.md
Name: coo_dense_compressor

Overview:
- Upstream stage of coo_simple_matmul: converts a dense row-streamed X matrix into the fixed-capacity COO vectors (x_data, x_row_table, x_col_table, x_valid) that the matmul consumes.
- Accepts one dense row of M elements per handshake beat and packs the non-zeros into an NZN-entry buffer, keeping at most NZN_ROW entries per row.
- After N rows it presents the whole COO frame with valid/ready and holds it until the consumer accepts it.

Parameters:
- N, 2, rows of X (rows per frame).
- M, 2, columns of X (elements per input beat).
- X_WIDTH, 8, element width in bits.
- ADDR_WIDTH, 16, row/column index width; must satisfy 2**ADDR_WIDTH > max(N, M).
- NZN, 4, COO buffer capacity; must satisfy NZN <= N*M.
- NZN_ROW, 2, maximum non-zeros kept per row; must satisfy NZN_ROW <= M.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  X_WIDTH x M  one dense row; in_data[m] is column m.
- in_valid  in  1  row valid.
- in_ready  out  1  row accepted when in_valid && in_ready.
- x_data  out  X_WIDTH x NZN  packed non-zero values.
- x_row_table  out  ADDR_WIDTH x NZN  row index per entry.
- x_col_table  out  ADDR_WIDTH x NZN  column index per entry.
- x_valid  out  1  COO frame valid.
- x_ready  in  1  consumer accepts the frame.

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: state=FILL, row_cnt=0, fill_cnt=0, in_ready=1, x_valid=0. All buffer slots are set to data 0, row=PAD_ROW (all ones), col 0.
- FSM has two states, FILL and EMIT.
  - FILL: in_ready=1, x_valid=0.
    - On each accepted beat, scan the row left to right (m=0..M-1). Element m is non-zero when in_data[m] != 0.
    - The first min(NZN_ROW, NZN-fill_cnt) non-zeros are written to slots fill_cnt, fill_cnt+1, ... with row=row_cnt, col=m.
    - fill_cnt advances by the number written. row_cnt increments.
    - Compaction is combinational (prefix count over the row), so one row is processed per cycle.
    - When the beat with row_cnt==N-1 is accepted, go to EMIT next cycle.
  - EMIT: in_ready=0, x_valid=1. Outputs come directly from registers and stay stable until the handshake.
    - On x_valid && x_ready: go to FILL, row_cnt=0, fill_cnt=0, and refill all slots with padding (same as reset) in that cycle.
- Latency: x_valid rises the cycle after the last row's handshake.
- Throughput: one frame per N+1 cycles, with no back-to-back overlap.
- Padding: slots not filled keep data 0, row PAD_ROW. A downstream row fetch for any valid row index therefore never matches a pad.
- Entry order: ascending row, then ascending column within a row.
- Row overflow (more than NZN_ROW non-zeros in a row): extra non-zeros in higher columns are dropped silently.
- Frame overflow (fill_cnt reaches NZN): the remaining non-zeros in the frame are dropped. Rows are still counted and the frame still completes after N rows.
- All-zero row: row_cnt advances, no slots are written.
- in_valid held high in EMIT: not accepted; the data must be held per valid/ready rules.
- rst asserted mid-FILL or mid-EMIT: the partial frame is discarded and all registers take their reset values next cycle.
- Protocol: the consumer never sees x_valid drop without a handshake.

Optional Feature:
- Macro COO_COMPRESSOR_OVERFLOW_STATUS_EN.
- When defined:
  - Adds output out_overflow (1 bit). It is registered, valid alongside x_valid, and set when any non-zero was dropped in the current frame (row or frame overflow).
  - Cleared on reset and on frame handshake.
  - Adds output dropped_cnt (width $clog2(N*M+1)), the count of dropped non-zeros in the frame.
- When undefined: no extra ports or logic; drops are silent.

Decomposition:
- Package coo_pkg holds:
  - the PAD_ROW constant (all-ones of ADDR_WIDTH), as a parameterised function/localparam helper;
  - the FSM state enum typedef {FILL, EMIT};
  - a coo_entry_t packing of data/row/col (used via parameterised macros).
- One sub-module, coo_row_compactor. It is combinational: given a dense row, a base slot and remaining capacity, it produces per-column write enables, target slot indices and the written count.

Test Plan:
- N=2,M=2,NZN=4,NZN_ROW=2; rows [3,0],[0,5] -> entries (3,r0,c0),(5,r1,c1), slots 2-3 are pads (data 0, row 0xFFFF); x_valid 1 cycle after the second beat.
- Row overflow with M=4,NZN_ROW=2: row [1,2,3,4] -> only (1,c0),(2,c1) are kept; with the macro, out_overflow=1 and dropped_cnt=2.
- Frame overflow with N=3,M=2,NZN=4: rows [1,1],[2,2],[3,3] -> the slots hold the row0 and row1 entries, row 2 is dropped, and the frame still emits after the third beat.
- Backpressure: hold x_ready=0 for 5 cycles in EMIT -> outputs stable, in_ready=0; when x_ready=1 the next cycle is FILL with in_ready=1 and padding restored.
- Reset mid-frame: accept row0 [7,0], assert rst -> next frame rows [0,0],[0,9] emit only (9,r1,c1) with no stale 7.
- All-zero frame -> x_valid asserted with all slots padded.
